// File: rtl/stream_demux.sv
// Packet-aware 1-to-N stream demultiplexer with one output register stage.
// Packets whose first-beat select is out of range are swallowed and counted.
module stream_demux #(
   parameter int DATA_W = 8,
   parameter int N_OUT  = 8,
   parameter int SEL_W  = $clog2(N_OUT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [SEL_W-1:0]  s_sel,
   input  logic              s_last,
   output logic [N_OUT-1:0]  m_valid,
   input  logic [N_OUT-1:0]  m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic [7:0]        drop_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   localparam logic [SEL_W:0] N_OUT_C = (SEL_W+1)'(N_OUT);

   state_t              r_state;
   logic [SEL_W-1:0]    r_pkt_sel;
   logic                r_out_valid;
   logic [SEL_W-1:0]    r_out_sel;
   logic [DATA_W-1:0]   r_m_data;
   logic                r_m_last;
   logic [7:0]          r_drop_cnt;

   logic [N_OUT-1:0]    w_m_valid;
   logic                w_out_ready;
   logic                w_sel_bad;
   logic                w_s_ready;
   logic                w_accept;
   logic                w_fwd;
   logic [SEL_W-1:0]    w_dest;

   // One-hot channel decode of the held output beat
   always_comb begin
      w_m_valid = {N_OUT{1'b0}};
      for (int i = 0; i < N_OUT; i++) begin
         if (r_out_valid && (r_out_sel == SEL_W'(i))) begin
            w_m_valid[i] = 1'b1;
         end else begin
            w_m_valid[i] = 1'b0;
         end
      end
   end

   assign w_out_ready = |(w_m_valid & m_ready);
   assign w_sel_bad   = ({1'b0, s_sel} >= N_OUT_C);

   // Input handshake: dropped beats never wait on the output stage
   always_comb begin
      w_s_ready = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_sel_bad) begin
               w_s_ready = 1'b1;
            end else begin
               w_s_ready = !r_out_valid || w_out_ready;
            end
         end
         ST_FWD:  w_s_ready = !r_out_valid || w_out_ready;
         ST_DROP: w_s_ready = 1'b1;
         default: w_s_ready = 1'b0;
      endcase
      if (rst) begin
         w_s_ready = 1'b0;
      end else begin
         w_s_ready = w_s_ready;
      end
   end

   assign w_accept = s_valid && w_s_ready;
   assign w_fwd    = w_accept && (((r_state == ST_IDLE) && !w_sel_bad) || (r_state == ST_FWD));
   assign w_dest   = (r_state == ST_IDLE) ? s_sel : r_pkt_sel;

   // Packet FSM, latched destination and saturating drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_pkt_sel  <= {SEL_W{1'b0}};
         r_drop_cnt <= 8'd0;
      end else if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               if (w_sel_bad) begin
                  r_state <= s_last ? ST_IDLE : ST_DROP;
                  if (r_drop_cnt != 8'd255) begin
                     r_drop_cnt <= r_drop_cnt + 8'd1;
                  end
               end else begin
                  r_pkt_sel <= s_sel;
                  r_state   <= s_last ? ST_IDLE : ST_FWD;
               end
            end
            ST_FWD:  r_state <= s_last ? ST_IDLE : ST_FWD;
            ST_DROP: r_state <= s_last ? ST_IDLE : ST_DROP;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Output stage: reload on accept (even while draining), clear on drain
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_sel   <= {SEL_W{1'b0}};
         r_m_data    <= {DATA_W{1'b0}};
         r_m_last    <= 1'b0;
      end else if (w_fwd) begin
         r_out_valid <= 1'b1;
         r_out_sel   <= w_dest;
         r_m_data    <= s_data;
         r_m_last    <= s_last;
      end else if (w_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign s_ready  = w_s_ready;
   assign m_valid  = w_m_valid;
   assign m_data   = r_m_data;
   assign m_last   = r_m_last;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux: an 8-channel instance for
// routing/backpressure/reset and a 6-channel instance for drop handling.
module tb_stream_demux;

   logic       clk;
   logic       rst;

   logic       s_valid, s_ready, s_last, m_last;
   logic [7:0] s_data, m_data, m_valid, m_ready, drop_cnt;
   logic [2:0] s_sel;

   logic       s6_valid, s6_ready, s6_last, m6_last;
   logic [7:0] s6_data, m6_data, drop6_cnt;
   logic [2:0] s6_sel;
   logic [5:0] m6_valid, m6_ready;

   int n_total;
   int n_bad;

   stream_demux #(.DATA_W(8), .N_OUT(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .drop_cnt(drop_cnt)
   );

   stream_demux #(.DATA_W(8), .N_OUT(6)) u_dut6 (
      .clk(clk), .rst(rst),
      .s_valid(s6_valid), .s_ready(s6_ready), .s_data(s6_data), .s_sel(s6_sel), .s_last(s6_last),
      .m_valid(m6_valid), .m_ready(m6_ready), .m_data(m6_data), .m_last(m6_last),
      .drop_cnt(drop6_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle on the 8-channel instance; checks afterwards see the previous edge's state
   task automatic drv8(input logic v, input logic [7:0] d, input logic [2:0] sel,
                       input logic l, input logic [7:0] rdy);
      @(negedge clk);
      s_valid = v; s_data = d; s_sel = sel; s_last = l; m_ready = rdy;
      #1;
   endtask

   task automatic drv6(input logic v, input logic [7:0] d, input logic [2:0] sel, input logic l);
      @(negedge clk);
      s6_valid = v; s6_data = d; s6_sel = sel; s6_last = l;
      #1;
   endtask

   initial begin
      n_total = 0; n_bad = 0;
      rst = 1'b1;
      s_valid = 1'b1; s_data = 8'h00; s_sel = 3'd0; s_last = 1'b0; m_ready = 8'hFF;
      s6_valid = 1'b0; s6_data = 8'h00; s6_sel = 3'd0; s6_last = 1'b0; m6_ready = 6'h3F;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_sready", 32'(s_ready), 32'd0);
      chk("rst_mvalid", 32'(m_valid), 32'd0);
      chk("rst_mdata", 32'(m_data), 32'd0);
      chk("rst_mlast", 32'(m_last), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b0;
      s_valid = 1'b0;

      // 3-beat packet to channel 5; later s_sel values must be ignored
      drv8(1'b1, 8'h11, 3'd5, 1'b0, 8'hFF);
      chk("s1_rdy", 32'(s_ready), 32'd1);
      chk("s1_mv0", 32'(m_valid), 32'h00);
      drv8(1'b1, 8'h22, 3'd2, 1'b0, 8'hFF);
      chk("s1_mv1", 32'(m_valid), 32'h20);
      chk("s1_d1", 32'(m_data), 32'h11);
      chk("s1_l1", 32'(m_last), 32'd0);
      drv8(1'b1, 8'h33, 3'd2, 1'b1, 8'hFF);
      chk("s1_mv2", 32'(m_valid), 32'h20);
      chk("s1_d2", 32'(m_data), 32'h22);
      chk("s1_l2", 32'(m_last), 32'd0);
      drv8(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
      chk("s1_mv3", 32'(m_valid), 32'h20);
      chk("s1_d3", 32'(m_data), 32'h33);
      chk("s1_l3", 32'(m_last), 32'd1);
      drv8(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
      chk("s1_idle", 32'(m_valid), 32'h00);

      // Back-to-back single-beat packets to channels 0 and 7
      drv8(1'b1, 8'hA0, 3'd0, 1'b1, 8'hFF);
      chk("s2_rdy0", 32'(s_ready), 32'd1);
      drv8(1'b1, 8'hA1, 3'd7, 1'b1, 8'hFF);
      chk("s2_rdy1", 32'(s_ready), 32'd1);
      chk("s2_mv0", 32'(m_valid), 32'h01);
      chk("s2_d0", 32'(m_data), 32'hA0);
      drv8(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
      chk("s2_mv1", 32'(m_valid), 32'h80);
      chk("s2_d1", 32'(m_data), 32'hA1);
      drv8(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
      chk("s2_idle", 32'(m_valid), 32'h00);

      // Channel 3 blocked for 4 cycles under a 2-beat packet
      drv8(1'b1, 8'hB1, 3'd3, 1'b0, 8'hF7);
      chk("s3_rdy0", 32'(s_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         drv8(1'b1, 8'hB2, 3'd3, 1'b1, 8'hF7);
         chk("s3_stall_rdy", 32'(s_ready), 32'd0);
         chk("s3_stall_mv", 32'(m_valid), 32'h08);
         chk("s3_stall_d", 32'(m_data), 32'hB1);
         chk("s3_stall_l", 32'(m_last), 32'd0);
      end
      drv8(1'b1, 8'hB2, 3'd3, 1'b1, 8'hFF);
      chk("s3_rdy1", 32'(s_ready), 32'd1);
      chk("s3_mv1", 32'(m_valid), 32'h08);
      chk("s3_d1", 32'(m_data), 32'hB1);
      drv8(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
      chk("s3_mv2", 32'(m_valid), 32'h08);
      chk("s3_d2", 32'(m_data), 32'hB2);
      chk("s3_l2", 32'(m_last), 32'd1);
      drv8(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
      chk("s3_idle", 32'(m_valid), 32'h00);

      // Invalid packets on the 6-channel instance
      drv6(1'b1, 8'hD1, 3'd7, 1'b0);
      chk("s4_rdy0", 32'(s6_ready), 32'd1);
      chk("s4_drop0", 32'(drop6_cnt), 32'd0);
      drv6(1'b1, 8'hD2, 3'd0, 1'b1);
      chk("s4_rdy1", 32'(s6_ready), 32'd1);
      chk("s4_mv1", 32'(m6_valid), 32'h00);
      chk("s4_drop1", 32'(drop6_cnt), 32'd1);
      drv6(1'b0, 8'h00, 3'd0, 1'b0);
      chk("s4_mv2", 32'(m6_valid), 32'h00);
      chk("s4_drop2", 32'(drop6_cnt), 32'd1);
      for (int k = 0; k < 128; k++) begin
         drv6(1'b1, 8'(k), 3'd6, 1'b1);
         chk("s4_loop_rdy", 32'(s6_ready), 32'd1);
      end
      drv6(1'b0, 8'h00, 3'd0, 1'b0);
      chk("s4_drop129", 32'(drop6_cnt), 32'd129);
      for (int k = 0; k < 128; k++) begin
         drv6(1'b1, 8'(k), 3'd7, 1'b1);
         chk("s4_loop_mv", 32'(m6_valid), 32'h00);
      end
      drv6(1'b0, 8'h00, 3'd0, 1'b0);
      chk("s4_drop_sat", 32'(drop6_cnt), 32'd255);
      drv6(1'b1, 8'hE5, 3'd5, 1'b1);
      chk("s4_rdy_edge", 32'(s6_ready), 32'd1);
      drv6(1'b0, 8'h00, 3'd0, 1'b0);
      chk("s4_mv_edge", 32'(m6_valid), 32'h20);
      chk("s4_d_edge", 32'(m6_data), 32'hE5);
      chk("s4_drop_hold", 32'(drop6_cnt), 32'd255);

      // Reset in the middle of a packet to channel 4
      drv8(1'b1, 8'hC1, 3'd4, 1'b0, 8'hFF);
      @(negedge clk);
      rst = 1'b1; s_valid = 1'b1; s_data = 8'hC2; s_sel = 3'd4; s_last = 1'b0;
      #1;
      chk("s5_rst_rdy", 32'(s_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0; s_valid = 1'b0;
      #1;
      chk("s5_mv_clr", 32'(m_valid), 32'h00);
      chk("s5_drop_clr", 32'(drop_cnt), 32'd0);
      drv8(1'b1, 8'h5A, 3'd1, 1'b1, 8'hFF);
      chk("s5_rdy", 32'(s_ready), 32'd1);
      drv8(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
      chk("s5_mv", 32'(m_valid), 32'h02);
      chk("s5_d", 32'(m_data), 32'h5A);
      drv8(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
      chk("s5_idle", 32'(m_valid), 32'h00);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
